// File: rtl/md_sequencer.sv
// Multicycle MULT/DIV sequencer for the HI/LO registers: signed shift-add multiply
// and restoring divide, one bit per cycle, with a divide-by-zero fast path.
module md_sequencer #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              op,
    input  logic              abort,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic              busy,
    output logic              done,
    output logic              div0,
    output logic              hi_write,
    output logic              lo_write,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, FIX, WRITE, ZERO} state_t;

    state_t state, next_state;

    logic              op_q, sign_a, sign_b;
    logic [DATA_W-1:0] a_q, b_q, operand, hi_acc, lo_acc;
    logic [CW-1:0]     count;
    logic              done_next, div0_next, write_next;

    logic [DATA_W-1:0]   mag_a, mag_b;
    logic [DATA_W:0]     mul_sum, rem_shift, trial;
    logic [2*DATA_W-1:0] mul_shift, prod, prod_fix;
    logic [DATA_W-1:0]   div_rem, fix_hi, fix_lo;
    logic                div_bit;

    assign busy  = (state != IDLE);
    assign mag_a = a_q[DATA_W-1] ? -a_q : a_q;
    assign mag_b = b_q[DATA_W-1] ? -b_q : b_q;

    // MULT: hi_acc is the running upper product, lo_acc the multiplier shifting out.
    assign mul_sum   = {1'b0, hi_acc} + (lo_acc[0] ? {1'b0, operand} : '0);
    assign mul_shift = {mul_sum, lo_acc[DATA_W-1:1]};

    // DIV: hi_acc is the partial remainder, lo_acc shifts dividend out and quotient in.
    assign rem_shift = {hi_acc, lo_acc[DATA_W-1]};
    assign trial     = rem_shift - {1'b0, operand};
    assign div_bit   = ~trial[DATA_W];
    assign div_rem   = div_bit ? trial[DATA_W-1:0] : rem_shift[DATA_W-1:0];

    assign prod     = {hi_acc, lo_acc};
    assign prod_fix = (sign_a ^ sign_b) ? -prod : prod;
    assign fix_hi   = op_q ? (sign_a ? -hi_acc : hi_acc) : prod_fix[2*DATA_W-1:DATA_W];
    assign fix_lo   = op_q ? ((sign_a ^ sign_b) ? -lo_acc : lo_acc) : prod_fix[DATA_W-1:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Pulses are decided one cycle early so they can be registered; abort wins over them.
    always_comb begin
        next_state = state;
        done_next  = 1'b0;
        div0_next  = 1'b0;
        write_next = 1'b0;
        if (abort && state != IDLE) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:  if (start) next_state = LOAD;
                LOAD: begin
                    if (op_q && b_q == '0) begin
                        next_state = ZERO;
                        done_next  = 1'b1;
                        div0_next  = 1'b1;
                    end else begin
                        next_state = RUN;
                    end
                end
                RUN:   if (count == LAST) next_state = FIX;
                FIX: begin
                    next_state = WRITE;
                    done_next  = 1'b1;
                    write_next = 1'b1;
                end
                WRITE: next_state = IDLE;
                ZERO:  next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            done     <= 1'b0;
            div0     <= 1'b0;
            hi_write <= 1'b0;
            lo_write <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
            op_q     <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            operand  <= '0;
            hi_acc   <= '0;
            lo_acc   <= '0;
            count    <= '0;
        end else begin
            done     <= done_next;
            div0     <= div0_next;
            hi_write <= write_next;
            lo_write <= write_next;
            if (write_next) begin
                hi_out <= fix_hi;
                lo_out <= fix_lo;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q <= op;
                        a_q  <= src_a;
                        b_q  <= src_b;
                    end
                end
                LOAD: begin
                    sign_a <= a_q[DATA_W-1];
                    sign_b <= b_q[DATA_W-1];
                    hi_acc <= '0;
                    count  <= '0;
                    if (op_q) begin
                        lo_acc  <= mag_a;
                        operand <= mag_b;
                    end else begin
                        lo_acc  <= mag_b;
                        operand <= mag_a;
                    end
                end
                RUN: begin
                    count <= count + 1'b1;
                    if (op_q) begin
                        hi_acc <= div_rem;
                        lo_acc <= {lo_acc[DATA_W-2:0], div_bit};
                    end else begin
                        {hi_acc, lo_acc} <= mul_shift;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: latency, signed results, div0, abort and async reset.
module tb_md_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        busy, done, div0, hi_write, lo_write;
    logic [31:0] hi_out, lo_out;

    int tests = 0;
    int failures = 0;
    int cyc = 0;

    md_sequencer #(.DATA_W(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .abort(abort),
        .src_a(src_a), .src_b(src_b), .busy(busy), .done(done), .div0(div0),
        .hi_write(hi_write), .lo_write(lo_write), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s (cycle %0d): observed %0h, expected %0h", tag, cyc, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Leaves the bench in cycle 0 with start driven; the previous op must already be idle.
    task automatic start_op(input logic o, input logic [31:0] a, input logic [31:0] b, input logic ab);
        step();
        check("idle_before_start", {busy, done}, 2'b00);
        cyc   = 0;
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        abort = ab;
    endtask

    task automatic run_op(input string tag, input logic o, input logic [31:0] a, input logic [31:0] b,
                          input logic ab, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        start_op(o, a, b, ab);
        step();
        start = 1'b0;
        abort = 1'b0;
        src_a = $urandom;
        src_b = $urandom;
        check({tag, "_busy"}, busy, 1'b1);
        for (int c = 2; c <= 34; c++) begin
            step();
            if (c == 5) begin
                start = 1'b1;
                op    = ~o;
            end
            if (c == 6) start = 1'b0;
            check({tag, "_no_early_pulse"}, {done, div0, hi_write, lo_write}, 4'b0000);
        end
        step();
        check({tag, "_pulses"}, {done, div0, hi_write, lo_write}, 4'b1011);
        check({tag, "_hi"}, hi_out, exp_hi);
        check({tag, "_lo"}, lo_out, exp_lo);
    endtask

    initial begin
        #1 reset = 1'b0;
        #2;
        check("reset_flags", {busy, done, div0, hi_write, lo_write}, 5'b0);
        check("reset_hi", hi_out, 32'h0);
        check("reset_lo", lo_out, 32'h0);
        step();
        step();
        reset = 1'b1;

        run_op("mult_7_m3", 1'b0, 32'd7, 32'hFFFFFFFD, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);

        // Divide by zero: pulse at cycle 2, results untouched, idle at cycle 3.
        start_op(1'b1, 32'd5, 32'd0, 1'b0);
        step();
        start = 1'b0;
        check("div0_c1", {busy, done, div0}, 3'b100);
        step();
        check("div0_pulses", {done, div0, hi_write, lo_write}, 4'b1100);
        check("div0_hi_hold", hi_out, 32'hFFFFFFFF);
        check("div0_lo_hold", lo_out, 32'hFFFFFFFD);
        step();
        check("div0_c3", {busy, done, div0}, 3'b000);

        run_op("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h80000000);
        run_op("mult_min", 1'b0, 32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h0);
        run_op("mult_m1_m1", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h1);
        run_op("div_100_m7_abort_idle", 1'b1, 32'd100, 32'hFFFFFFF9, 1'b1, 32'd2, 32'hFFFFFFF2);

        // Abort at cycle 10 of a MULT, with a stray start at cycle 5.
        start_op(1'b0, 32'd3, 32'd5, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            step();
            start = (c == 5);
            if (c == 10) abort = 1'b1;
        end
        step();
        abort = 1'b0;
        check("abort_idle", {busy, done, div0, hi_write, lo_write}, 5'b0);
        check("abort_hi_hold", hi_out, 32'd2);
        check("abort_lo_hold", lo_out, 32'hFFFFFFF2);
        for (int c = 12; c <= 40; c++) begin
            step();
            check("abort_stays_idle", {busy, done, hi_write}, 3'b000);
        end

        // Asynchronous reset in the middle of a MULT.
        start_op(1'b0, 32'd7, 32'hFFFFFFFD, 1'b0);
        step();
        start = 1'b0;
        for (int c = 2; c <= 20; c++) step();
        check("pre_reset_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("midop_reset_flags", {busy, done, div0, hi_write, lo_write}, 5'b0);
        check("midop_reset_hi", hi_out, 32'h0);
        check("midop_reset_lo", lo_out, 32'h0);
        step();
        reset = 1'b1;
        step();
        check("post_reset_idle", {busy, done}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
